// File: rtl/apb_regs_pkg.sv
// Shared types and address-map constants for the APB slave front end.
// Pulled in by the decoder and the control block.
package apb_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;
    localparam int IDX_W = 8;

    // Default register map; instances may override these through their parameters.
    localparam int DEF_REGWN            = 5;
    localparam int DEF_REGRN            = 3;
    localparam int DEF_REGR_ADDR_OFFSET = 5;
    localparam int DEF_REGR_ADDR_END    = DEF_REGR_ADDR_OFFSET + DEF_REGRN;

    typedef struct packed {
        logic             rw_hit;
        logic             ro_hit;
        logic             err;
        logic [IDX_W-1:0] index;
    } dec_t;

endpackage

// File: rtl/apb_slave_ctrl_if.sv
// APB bus signals shared by the master (bench or bridge) and this slave.
interface apb_slave_ctrl_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Pure combinational map of an APB address and direction onto the two register banks.
module apb_addr_decode
    import apb_regs_pkg::*;
#(
    parameter int AWIDTH           = 4,
    parameter int REGWN            = DEF_REGWN,
    parameter int REGRN            = DEF_REGRN,
    parameter int REGR_ADDR_OFFSET = DEF_REGR_ADDR_OFFSET
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic              write,
    output dec_t              dec
);

    logic [31:0] addr_w;
    logic [31:0] ro_off;

    assign addr_w = 32'(addr);
    assign ro_off = addr_w - 32'(REGR_ADDR_OFFSET);

    always_comb begin
        dec = '0;
        if (addr_w < 32'(REGWN)) begin
            dec.rw_hit = 1'b1;
            dec.index  = IDX_W'(addr_w);
        end else if (addr_w >= 32'(REGR_ADDR_OFFSET) &&
                     addr_w < 32'(REGR_ADDR_OFFSET + REGRN)) begin
            // The RO bank has no write path, so a write that lands here is an error.
            if (write) begin
                dec.err = 1'b1;
            end else begin
                dec.ro_hit = 1'b1;
                dec.index  = IDX_W'(ro_off);
            end
        end else begin
            dec.err = 1'b1;
        end
    end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave front end: setup/access handshake with programmable wait states,
// one-hot register selects for the RW and RO banks, and read-data return.
module apb_slave_ctrl
    import apb_regs_pkg::*;
#(
    parameter int AWIDTH           = 4,
    parameter int DWIDTH           = 8,
    parameter int REGWN            = DEF_REGWN,
    parameter int REGRN            = DEF_REGRN,
    parameter int REGR_ADDR_OFFSET = DEF_REGR_ADDR_OFFSET,
    parameter int WAIT_STATES      = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_slave_ctrl_if.slave   apb,
    output logic [REGWN-1:0]  regw_rsel,
    output logic [REGWN-1:0]  regw_wsel,
    output logic [REGRN-1:0]  regr_rsel,
    output logic [DWIDTH-1:0] reg_wdata,
    input  logic [DWIDTH-1:0] regw_rdata,
    input  logic [DWIDTH-1:0] regr_rdata
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dec_t              dec, dec_q, dec_d;
    logic              write_q, write_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [REGWN-1:0]  regw_rsel_q, regw_rsel_d;
    logic [REGWN-1:0]  regw_wsel_q, regw_wsel_d;
    logic [REGRN-1:0]  regr_rsel_q, regr_rsel_d;
    logic              enter_resp;
    logic              rd_valid;

    apb_addr_decode #(
        .AWIDTH           (AWIDTH),
        .REGWN            (REGWN),
        .REGRN            (REGRN),
        .REGR_ADDR_OFFSET (REGR_ADDR_OFFSET)
    ) u_decode (
        .addr  (apb.PADDR),
        .write (apb.PWRITE),
        .dec   (dec)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_d       = dec_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        regw_wsel_d = '0;
        regw_rsel_d = regw_rsel_q;
        regr_rsel_d = regr_rsel_q;
        enter_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                regw_rsel_d = '0;
                regr_rsel_d = '0;
                // Only a proper setup phase starts a transfer; a stray access phase is ignored.
                if (apb.PSEL && !apb.PENABLE) begin
                    dec_d   = dec;
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    if (dec.rw_hit && !apb.PWRITE) regw_rsel_d = REGWN'(1) << dec.index;
                    if (dec.ro_hit)                regr_rsel_d = REGRN'(1) << dec.index;
                    if (WAIT_STATES == 0) enter_resp = 1'b1;
                    else                  state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d     = ST_IDLE;
                    regw_rsel_d = '0;
                    regr_rsel_d = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                regw_rsel_d = '0;
                regr_rsel_d = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                regw_rsel_d = '0;
                regr_rsel_d = '0;
            end
        endcase

        // Response-cycle outputs are registered so they line up with the RESP state.
        if (enter_resp) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = dec_d.err;
            if (dec_d.rw_hit && write_d) regw_wsel_d = REGWN'(1) << dec_d.index;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dec_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            regw_rsel_q <= '0;
            regw_wsel_q <= '0;
            regr_rsel_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            regw_rsel_q <= regw_rsel_d;
            regw_wsel_q <= regw_wsel_d;
            regr_rsel_q <= regr_rsel_d;
        end
    end

    assign rd_valid = (state_q == ST_RESP) && !write_q && !dec_q.err;

    assign apb.PRDATA  = !rd_valid     ? '0 :
                         dec_q.rw_hit  ? regw_rdata :
                         dec_q.ro_hit  ? regr_rdata : '0;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign regw_rsel   = regw_rsel_q;
    assign regw_wsel   = regw_wsel_q;
    assign regr_rsel   = regr_rsel_q;
    assign reg_wdata   = wdata_q;

endmodule

// File: doc/apb_slave_ctrl.md
Name: apb_slave_ctrl

Overview:
- APB slave front end that sits directly upstream of the register file.
- Implements the APB setup/access handshake with a programmable number of wait states.
- Decodes PADDR into one-hot read/write selects for the RW bank (REGWN registers) and the RO bank (REGRN registers).
- Returns register read data on PRDATA, with PREADY/PSLVERR generation.

Parameters:
AWIDTH, 4, APB address width
DWIDTH, 8, data width
REGWN, 5, number of RW registers, addresses 0..REGWN-1
REGRN, 3, number of RO registers, addresses REGR_ADDR_OFFSET..REGR_ADDR_OFFSET+REGRN-1
REGR_ADDR_OFFSET, 5, base address of RO bank; must be >= REGWN
WAIT_STATES, 0, PREADY-low cycles inserted in access phase (0..15)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1=write, 0=read
PADDR  in  AWIDTH  byte/word address (word granularity)
PWDATA  in  DWIDTH  write data
PRDATA  out  DWIDTH  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid only with PREADY
regw_rsel  out  REGWN  one-hot RW-register read select
regw_wsel  out  REGWN  one-hot RW-register write strobe
regr_rsel  out  REGRN  one-hot RO-register read select
reg_wdata  out  DWIDTH  latched write data to register file
regw_rdata  in  DWIDTH  read data from RW bank (combinational on regw_rsel)
regr_rdata  in  DWIDTH  read data from RO bank (combinational on regr_rsel)

Behaviour:
- Reset: async assert on PRESETn=0. State=IDLE; all outputs 0; wait counter 0; latched addr/data/dir 0.
- FSM states:
  - IDLE: on PSEL=1 & PENABLE=0, latch PADDR, PWRITE, PWDATA, decode, load cnt=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP. PSEL=1 & PENABLE=1 seen in IDLE (no setup) is ignored.
  - WAIT: cnt decrements each cycle; go to RESP when cnt==1. If PSEL=0, abort to IDLE: no strobe, no PREADY.
  - RESP: lasts exactly one cycle, then unconditionally to IDLE. The next setup can be sampled on the following cycle.
- Registered outputs:
  - PREADY=1 only in RESP.
  - PSLVERR=1 in RESP if the transfer errored.
  - regw_wsel bit = 1 in RESP only, for a valid write (single-cycle pulse).
  - rsel vectors are held through WAIT and RESP for valid reads, and are 0 otherwise.
- Latency: with WAIT_STATES=N, PREADY rises N+1 cycles after the setup-phase edge. Zero-wait gives a standard 2-cycle APB transfer.
- Decode:
  - addr < REGWN selects RW bank.
  - REGR_ADDR_OFFSET <= addr < REGR_ADDR_OFFSET+REGRN selects RO bank, index addr-REGR_ADDR_OFFSET.
  - Anything else is an error.
  - A write to the RO bank is an error.
  - An error transfer drives no selects or strobes, PRDATA=0, PSLVERR=1.
- PRDATA: combinational; equals the selected bank rdata when state==RESP and the transfer is a valid read; otherwise 0.
- reg_wdata holds the latched PWDATA until the next setup.
- Reset mid-transfer: immediate return to IDLE, all outputs 0; no partial strobe.
- All selects are guaranteed one-hot or zero; never more than one bit set across both banks.

Decomposition:
- Shared package apb_regs_pkg: state encoding (IDLE/WAIT/RESP), address-map constants derived from REGWN/REGRN/REGR_ADDR_OFFSET, and a decode-result struct {rw_hit, ro_hit, err, index}.
- One natural sub-module: apb_addr_decode, a pure combinational map of address+direction to decode result. The FSM, counter and output registers stay in apb_slave_ctrl.

Test Plan:
- Zero-wait write: WAIT_STATES=0, write PADDR=2, PWDATA=0xA5 -> regw_wsel=5'b00100 for one cycle with PREADY=1, reg_wdata=0xA5, PSLVERR=0.
- Read RO bank with waits: WAIT_STATES=2, read PADDR=6, regr_rdata=0x3C -> PREADY low 2 access cycles then high; regr_rsel=3'b010 throughout; PRDATA=0x3C only when PREADY=1.
- Error cases:
  - Write PADDR=5 -> PSLVERR=1 with PREADY, no wsel.
  - Read PADDR=15 -> PSLVERR=1, PRDATA=0.
- Abort: WAIT_STATES=3, PSEL dropped in 2nd wait cycle -> FSM to IDLE, PREADY never asserted, no strobe; the next transfer completes normally.
- Back-to-back: write addr 0 then read addr 4 with no idle cycles -> both complete, PREADY pulses separated by exactly one setup cycle.
- Async reset: PRESETn low during WAIT -> all outputs 0 immediately, state IDLE; PENABLE=1 without setup after reset is ignored.
